// File: rtl/lcd_key_overlay.sv
// Keyboard-overlay renderer: maps LCD sync counters and per-key hold timers to RGB.
// Two pixel-strobe pipeline stages: column tracking, then colour selection.
module lcd_key_overlay #(
  parameter int         NUM_KEYS    = 8,
  parameter int         KEY_W       = 60,
  parameter int         H_ACTIVE    = 480,
  parameter int         KEY_TOP     = 80,
  parameter int         KEY_BOT     = 271,
  parameter int         HOLD_FRAMES = 15,
  parameter logic [7:0] BG_BLUE     = 8'h20
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] hcount,
  input  logic [8:0] vcount,
  input  logic       de,
  input  logic       frame_start,
  input  logic       key_valid,
  input  logic [3:0] key_idx,
  output logic [7:0] data_RED,
  output logic [7:0] data_GREEN,
  output logic [7:0] data_BLUE,
  output logic       pix_valid
);

  localparam int SUB_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  logic [7:0]       r_hold [NUM_KEYS];
  logic [15:0]      w_litMask;
  logic [3:0]       r_col;
  logic [SUB_W-1:0] r_sub;
  logic [8:0]       r_v;
  logic             r_de;
  logic             w_de;
  logic [23:0]      w_rgb;

  // A touch reloads its key even when a frame pulse lands on the same cycle.
  always_ff @(posedge Clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_KEYS; k++) r_hold[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_valid && (key_idx == 4'(k)))
          r_hold[k] <= 8'(HOLD_FRAMES);
        else if (frame_start && (r_hold[k] != 8'd0))
          r_hold[k] <= r_hold[k] - 8'd1;
      end
    end
  end

  always_comb begin
    w_litMask = '0;
    for (int k = 0; k < NUM_KEYS; k++) w_litMask[k] = |r_hold[k];
  end

  assign w_de = de && (hcount < 10'(H_ACTIVE));

  // Column/sub-pixel counters replace hcount / KEY_W; col saturates past the last key.
  always_ff @(posedge Clk) begin
    if (!rst) begin
      r_col <= '0;
      r_sub <= '0;
      r_v   <= '0;
      r_de  <= 1'b0;
    end else if (pix_en) begin
      r_v  <= vcount;
      r_de <= w_de;
      if (hcount == 10'd0) begin
        r_col <= '0;
        r_sub <= '0;
      end else if (r_sub == SUB_W'(KEY_W - 1)) begin
        r_sub <= '0;
        if (r_col != 4'(NUM_KEYS)) r_col <= r_col + 4'd1;
      end else begin
        r_sub <= r_sub + SUB_W'(1);
      end
    end
  end

  always_comb begin
    w_rgb = 24'h000000;
    if (!r_de)
      w_rgb = 24'h000000;
    else if ((r_v < 9'(KEY_TOP)) || (r_v > 9'(KEY_BOT)) || (r_col == 4'(NUM_KEYS)))
      w_rgb = {16'h0000, BG_BLUE};
    else if ((r_sub == '0) || (r_v == 9'(KEY_TOP)))
      w_rgb = 24'h000000;
    else if (w_litMask[r_col])
      w_rgb = 24'hFF0000;
    else
      w_rgb = 24'hFFFFFF;
  end

  always_ff @(posedge Clk) begin
    if (!rst) begin
      data_RED   <= '0;
      data_GREEN <= '0;
      data_BLUE  <= '0;
      pix_valid  <= 1'b0;
    end else if (pix_en) begin
      data_RED   <= w_rgb[23:16];
      data_GREEN <= w_rgb[15:8];
      data_BLUE  <= w_rgb[7:0];
      pix_valid  <= r_de;
    end
  end

endmodule

// File: tb/tb_lcd_key_overlay.sv
// Directed bench for lcd_key_overlay: default instance plus a 12-key, 40-pixel, 1-frame variant.
module tb_lcd_key_overlay;

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en = 1'b0;
  logic [9:0] hcount = '0;
  logic [8:0] vcount = '0;
  logic       de = 1'b0;
  logic       frame_start = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_idx = '0;
  logic [7:0] red1, green1, blue1, red2, green2, blue2;
  logic       pv1, pv2;

  int checks = 0;
  int failures = 0;

  logic [23:0] rgb1 [480];
  logic [23:0] rgb2 [480];
  logic        val1 [480];

  always #5 Clk = ~Clk;

  lcd_key_overlay dut (
    .Clk(Clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount), .de(de),
    .frame_start(frame_start), .key_valid(key_valid), .key_idx(key_idx),
    .data_RED(red1), .data_GREEN(green1), .data_BLUE(blue1), .pix_valid(pv1)
  );

  lcd_key_overlay #(.NUM_KEYS(12), .KEY_W(40), .HOLD_FRAMES(1)) dut2 (
    .Clk(Clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount), .de(de),
    .frame_start(frame_start), .key_valid(key_valid), .key_idx(key_idx),
    .data_RED(red2), .data_GREEN(green2), .data_BLUE(blue2), .pix_valid(pv2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel strobe followed by an idle clock, so outputs must hold between strobes.
  task automatic applyStimulus(input logic [9:0] h, input logic [8:0] v, input logic d);
    @(negedge Clk);
    hcount = h; vcount = v; de = d; pix_en = 1'b1;
    @(negedge Clk);
    pix_en = 1'b0;
    @(negedge Clk);
  endtask

  task automatic pulseEvent(input logic kv, input logic [3:0] idx, input logic fs);
    @(negedge Clk);
    key_valid = kv; key_idx = idx; frame_start = fs;
    @(negedge Clk);
    key_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) pulseEvent(1'b0, 4'd0, 1'b1);
  endtask

  // Pixel p is visible after the strobe that presents hcount p+1.
  task automatic runLine(input logic [8:0] v, input logic d);
    for (int h = 0; h <= 480; h++) begin
      applyStimulus(10'(h), v, d && (h < 480));
      if (h >= 1) begin
        rgb1[h-1] = {red1, green1, blue1};
        rgb2[h-1] = {red2, green2, blue2};
        val1[h-1] = pv1;
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset_rgb", {red1, green1, blue1}, 24'h000000);
    checkOutput("reset_valid", pv1, 0);
    repeat (2) @(negedge Clk);
    rst = 1'b1;

    runLine(9'd100, 1'b1);
    checkOutput("h0_border", rgb1[0], 24'h000000);
    checkOutput("h60_border", rgb1[60], 24'h000000);
    checkOutput("h61_white", rgb1[61], 24'hFFFFFF);
    checkOutput("h61_valid", val1[61], 1);
    checkOutput("h180_border", rgb1[180], 24'h000000);
    checkOutput("h200_unlit", rgb1[200], 24'hFFFFFF);
    checkOutput("h420_border", rgb1[420], 24'h000000);
    checkOutput("h479_white", rgb1[479], 24'hFFFFFF);
    checkOutput("v2_h0_border", rgb2[0], 24'h000000);
    checkOutput("v2_h40_border", rgb2[40], 24'h000000);
    checkOutput("v2_h41_white", rgb2[41], 24'hFFFFFF);
    checkOutput("v2_h440_border", rgb2[440], 24'h000000);
    checkOutput("v2_h479_white", rgb2[479], 24'hFFFFFF);

    runLine(9'd50, 1'b1);
    checkOutput("v50_bg", rgb1[61], 24'h000020);
    checkOutput("v50_bg_v2", rgb2[41], 24'h000020);
    runLine(9'd80, 1'b1);
    checkOutput("v80_top_border", rgb1[61], 24'h000000);
    runLine(9'd271, 1'b1);
    checkOutput("v271_white", rgb1[61], 24'hFFFFFF);
    runLine(9'd272, 1'b1);
    checkOutput("v272_bg", rgb1[61], 24'h000020);
    runLine(9'd100, 1'b0);
    checkOutput("de0_rgb", rgb1[61], 24'h000000);
    checkOutput("de0_valid", val1[61], 0);

    pulseEvent(1'b1, 4'd3, 1'b0);
    checkOutput("hold3_load", dut.r_hold[3], 15);
    runLine(9'd100, 1'b1);
    checkOutput("key3_h180", rgb1[180], 24'h000000);
    checkOutput("key3_h181", rgb1[181], 24'hFF0000);
    checkOutput("key3_h239", rgb1[239], 24'hFF0000);
    checkOutput("key3_h240", rgb1[240], 24'h000000);
    checkOutput("key3_h241", rgb1[241], 24'hFFFFFF);
    frames(14);
    runLine(9'd100, 1'b1);
    checkOutput("key3_frame14", rgb1[200], 24'hFF0000);
    frames(1);
    runLine(9'd100, 1'b1);
    checkOutput("key3_frame15", rgb1[200], 24'hFFFFFF);

    pulseEvent(1'b1, 4'd5, 1'b0);
    frames(11);
    checkOutput("hold5_pre", dut.r_hold[5], 4);
    pulseEvent(1'b1, 4'd2, 1'b1);
    checkOutput("simul_hold2", dut.r_hold[2], 15);
    checkOutput("simul_hold5", dut.r_hold[5], 3);
    checkOutput("simul_hold3", dut.r_hold[3], 0);

    pulseEvent(1'b1, 4'd9, 1'b0);
    checkOutput("invalid_hold2", dut.r_hold[2], 15);
    checkOutput("invalid_hold5", dut.r_hold[5], 3);
    checkOutput("invalid_hold7", dut.r_hold[7], 0);
    runLine(9'd100, 1'b1);
    checkOutput("key2_lit", rgb1[130], 24'hFF0000);
    checkOutput("key5_lit", rgb1[301], 24'hFF0000);
    checkOutput("key6_unlit", rgb1[370], 24'hFFFFFF);
    checkOutput("v2_key9_lit", rgb2[370], 24'hFF0000);
    frames(1);
    runLine(9'd100, 1'b1);
    checkOutput("v2_key9_expired", rgb2[370], 24'hFFFFFF);
    checkOutput("key2_still_lit", rgb1[130], 24'hFF0000);

    for (int h = 0; h < 100; h++) applyStimulus(10'(h), 9'd100, 1'b1);
    @(negedge Clk);
    hcount = 10'd100; pix_en = 1'b1; rst = 1'b0;
    @(negedge Clk);
    pix_en = 1'b0;
    checkOutput("midreset_rgb", {red1, green1, blue1}, 24'h000000);
    checkOutput("midreset_valid", pv1, 0);
    checkOutput("midreset_hold2", dut.r_hold[2], 0);
    repeat (2) @(negedge Clk);
    rst = 1'b1;
    runLine(9'd100, 1'b1);
    checkOutput("post_reset_h60", rgb1[60], 24'h000000);
    checkOutput("post_reset_h61", rgb1[61], 24'hFFFFFF);
    checkOutput("post_reset_key2", rgb1[130], 24'hFFFFFF);
    checkOutput("post_reset_key5", rgb1[301], 24'hFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
